// File: rtl/osd_overlay_mixer.sv
// OSD overlay mixer: generates xpos/ypos for the OSD generator, delays video to match
// its latency and overlays the palette colour. Optional 50/50 blend: OSD_ALPHA_BLEND_EN.
module osd_overlay_mixer #(
   parameter int OSD_LATENCY    = 7,
   parameter int VS_ACTIVE_HIGH = 0,
   parameter int DATA_W         = 8
) (
   input  logic              vclk,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] r_i,
   input  logic [DATA_W-1:0] g_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              de_i,
   output logic [11:0]       xpos,
   output logic [10:0]       ypos,
   input  logic              osd_enable,
   input  logic [2:0]        osd_color,
   output logic [DATA_W-1:0] r_o,
   output logic [DATA_W-1:0] g_o,
   output logic [DATA_W-1:0] b_o,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              de_o
);
   localparam int NSTG  = OSD_LATENCY + 1;
   localparam int DLY_W = 3 * DATA_W + 3;

   logic        vs_act;
   logic        vs_act_q;
   logic        de_q;
   logic [11:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;

   assign vs_act = (VS_ACTIVE_HIGH != 0) ? vsync_i : ~vsync_i;

   always_comb begin
      xpos_d = 12'd0;
      if (de_i && de_q && (xpos_q != 12'hFFF))
         xpos_d = xpos_q + 12'd1;
      else if (de_i && de_q)
         xpos_d = xpos_q;
   end

   // A leading vsync edge beats the end-of-line increment in the same cycle.
   always_comb begin
      ypos_d = ypos_q;
      if (vs_act && !vs_act_q)
         ypos_d = 11'd0;
      else if (!de_i && de_q && (ypos_q != 11'h7FF))
         ypos_d = ypos_q + 11'd1;
   end

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i) begin
         vs_act_q <= 1'b0;
         de_q     <= 1'b0;
         xpos_q   <= 12'd0;
         ypos_q   <= 11'd0;
      end else begin
         vs_act_q <= vs_act;
         de_q     <= de_i;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
      end
   end

   assign xpos = xpos_q;
   assign ypos = ypos_q;

   logic [DLY_W-1:0] dly_q [NSTG];

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NSTG; i++)
            dly_q[i] <= '0;
      end else begin
         dly_q[0] <= {r_i, g_i, b_i, hsync_i, vsync_i, de_i};
         for (int i = 1; i < NSTG; i++)
            dly_q[i] <= dly_q[i-1];
      end
   end

   logic [DATA_W-1:0] dd_r, dd_g, dd_b;
   logic              dd_hs, dd_vs, dd_de;

   assign {dd_r, dd_g, dd_b, dd_hs, dd_vs, dd_de} = dly_q[NSTG-1];

   logic [DATA_W-1:0] ov_r, ov_g, ov_b;
   logic [DATA_W-1:0] r_d, g_d, b_d;

   assign ov_r = {DATA_W{osd_color[2]}};
   assign ov_g = {DATA_W{osd_color[1]}};
   assign ov_b = {DATA_W{osd_color[0]}};

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (dd_de && !osd_enable) begin
         r_d = dd_r;
         g_d = dd_g;
         b_d = dd_b;
      end else if (dd_de) begin
`ifdef OSD_ALPHA_BLEND_EN
         // Blue background is translucent; halves cannot overflow DATA_W.
         if (osd_color == 3'h1) begin
            r_d = {1'b0, dd_r[DATA_W-1:1]} + {1'b0, ov_r[DATA_W-1:1]};
            g_d = {1'b0, dd_g[DATA_W-1:1]} + {1'b0, ov_g[DATA_W-1:1]};
            b_d = {1'b0, dd_b[DATA_W-1:1]} + {1'b0, ov_b[DATA_W-1:1]};
         end else begin
            r_d = ov_r;
            g_d = ov_g;
            b_d = ov_b;
         end
`else
         r_d = ov_r;
         g_d = ov_g;
         b_d = ov_b;
`endif
      end
   end

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i) begin
         r_o     <= '0;
         g_o     <= '0;
         b_o     <= '0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
         de_o    <= 1'b0;
      end else begin
         r_o     <= r_d;
         g_o     <= g_d;
         b_o     <= b_d;
         hsync_o <= dd_hs;
         vsync_o <= dd_vs;
         de_o    <= dd_de;
      end
   end

endmodule

// File: doc/osd_overlay_mixer.md
Name: osd_overlay_mixer

Overview:
- Video-side partner of the OSD character generator. Drives the generator's xpos/ypos pixel coordinates from incoming sync/DE timing, and consumes its osd_enable/osd_color response.
- Delays the incoming video by the generator's pipeline latency, then replaces or blends the pixel with the 3-bit OSD palette colour.
- Sits in the vclk domain between the scaler output and the video transmitter.

Parameters:
- OSD_LATENCY, 7: vclk cycles from xpos/ypos leaving this block to the matching osd_enable/osd_color arriving back. Legal range 1..15.
- VS_ACTIVE_HIGH, 0: 1 = vsync_i active high; 0 = active low.
- DATA_W, 8: bits per colour component.

Ports:
- vclk  in  1  pixel clock
- rst_i  in  1  asynchronous active-high reset
- r_i, g_i, b_i  in  DATA_W each  input pixel
- hsync_i  in  1  input hsync, passed through only
- vsync_i  in  1  input vsync
- de_i  in  1  input data enable
- xpos  out  12  active-pixel column to the OSD generator
- ypos  out  11  active-line row to the OSD generator
- osd_enable  in  1  OSD pixel valid, from the generator
- osd_color  in  3  OSD palette index: bit2 = R, bit1 = G, bit0 = B
- r_o, g_o, b_o  out  DATA_W each  mixed pixel
- hsync_o, vsync_o, de_o  out  1 each  delayed sync and DE

Behaviour:
- Reset (async, rst_i high): xpos = 0, ypos = 0, all r/g/b_o = 0, hsync_o = vsync_o = de_o = 0. The delay line and edge-detect registers are also cleared.
- vs_act = vsync_i when VS_ACTIVE_HIGH = 1, else ~vsync_i. Edge detect uses the registered previous values vs_act_d and de_d.
- xpos register, updated every vclk:
  - de_i = 0: xpos <= 0.
  - de_i = 1 and de_d = 0 (first active pixel): xpos <= 0.
  - de_i = 1 and de_d = 1: xpos <= xpos + 1, saturating at 4095 (no wrap).
- ypos register, in priority order:
  - vs_act = 1 and vs_act_d = 0: ypos <= 0. This wins over a simultaneous DE fall.
  - else de_i = 0 and de_d = 1 (end of active line): ypos <= ypos + 1, saturating at 2047.
  - else hold.
- Coordinate timing: xpos/ypos for the pixel sampled at edge t are valid after edge t+1. The generator returns osd_enable/osd_color for that pixel after edge t+1+OSD_LATENCY.
- Delay line: {r, g, b, hsync, vsync, de} sampled at edge t is delayed OSD_LATENCY+1 stages. It is therefore aligned with osd_* at edge t+1+OSD_LATENCY.
- Output register at edge t+2+OSD_LATENCY. Total input-to-output latency = OSD_LATENCY+2 cycles (9 at default).
- Mix, evaluated on the aligned delayed data dd:
  - dd.de = 0: r/g/b_o <= 0.
  - dd.de = 1 and osd_enable = 0: r/g/b_o <= dd.r, dd.g, dd.b.
  - dd.de = 1 and osd_enable = 1: each component <= all-ones if its osd_color bit is set, else 0.
- Sync and DE outputs: hsync_o, vsync_o, de_o <= dd values unconditionally; never modified by the OSD.
- Boundary cases:
  - DE pulse of exactly one cycle: xpos = 0 for that pixel, and ypos increments on the following cycle.
  - vsync asserted mid-line: ypos cleared immediately; xpos unaffected.
  - Reset released mid-frame: ypos starts at 0. Coordinates are wrong until the next vsync edge; no recovery logic is provided.
  - osd_enable outside DE has no effect on the output.

Optional Feature:
- Macro: OSD_ALPHA_BLEND_EN.
- Defined: when osd_enable = 1, dd.de = 1 and osd_color == 3'h1 (the generator's blue background), each component is blended 50/50:
  - out = (dd_video >> 1) + (osd_value >> 1), where osd_value is all-ones or 0 per the colour bit.
  - Width stays DATA_W; no overflow is possible.
  - All other osd_color values remain opaque.
- Undefined: all OSD pixels are opaque. No blend logic is synthesised.

Test Plan:
- Reset: assert rst_i asynchronously mid-line -> all outputs 0 immediately; after release, xpos = ypos = 0 until activity.
- Timing counters: 3 lines of 10 DE pixels, 4 blanking cycles between lines, vsync edge before line 0 -> xpos runs 0..9 on each line; ypos is 0, 1, 2 on successive lines; de_o repeats the input DE pattern 9 cycles later.
- Latency and pass-through: input pixel (0x12, 0x34, 0x56) with osd_enable held 0 -> same values on r/g/b_o exactly 9 cycles later; hsync_o and vsync_o delayed 9 cycles.
- OSD opaque colour: model that drives osd_enable = 1, osd_color = 3'h6 for pixel xpos = 5, returned 7 cycles after xpos = 5 is presented -> that output pixel is (0xFF, 0xFF, 0x00); neighbouring pixels pass through unchanged.
- Saturation and priority:
  - 5000-pixel DE line -> xpos holds at 4095.
  - vsync edge coinciding with a DE falling edge -> ypos = 0, not incremented.
- OSD_ALPHA_BLEND_EN defined: video (0x80, 0x40, 0x20), osd_color = 3'h1 -> output (0x40, 0x20, 0x8F). With the macro undefined, the same stimulus gives (0x00, 0x00, 0xFF).
